// File: rtl/mem_stage.sv
// mem_stage: pipeline memory stage. Issues data-memory requests for loads and
// stores, stalls upstream while an access is outstanding, extracts and extends
// load data, and registers results toward write-back.
module mem_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_in,
  input  logic [31:0] iw_in,
  input  logic [31:0] alu_in,
  input  logic [31:0] rs2_data_in,
  input  logic [4:0]  wb_reg_in,
  input  logic        wb_enable_in,
  input  logic        mem_we_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        mem_stall,
  output logic        df_mem_enable,
  output logic [4:0]  df_mem_reg,
  output logic [31:0] df_mem_data,
  output logic [31:0] pc_out,
  output logic [31:0] iw_out,
  output logic [31:0] wb_data_out,
  output logic [4:0]  wb_reg_out,
  output logic        wb_enable_out,
  output logic        misalign_err
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned REGW = 5;
  localparam int unsigned BEW  = 4;
  localparam logic [XLEN-1:0] NOP_IW    = 32'h0000_0013;
  localparam logic [6:0]      OP_LOAD   = 7'b0000011;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t state_q, state_d;

  logic            is_load;
  logic            is_store;
  logic            misaligned;
  logic            access;
  logic [2:0]      func3;
  logic [1:0]      byte_off;
  logic [BEW-1:0]  store_be;
  logic [XLEN-1:0] store_data;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] wb_data_sel;

  logic [XLEN-1:0] pc_d, pc_q;
  logic [XLEN-1:0] iw_d, iw_q;
  logic [XLEN-1:0] wb_data_d, wb_data_q;
  logic [REGW-1:0] wb_reg_d, wb_reg_q;
  logic            wb_en_d, wb_en_q;
  logic            mis_d, mis_q;

  // Decode, alignment check, store lane formatting and load extraction
  always_comb begin
    func3      = iw_in[14:12];
    byte_off   = alu_in[1:0];
    is_store   = mem_we_in;
    is_load    = (iw_in[6:0] == OP_LOAD) && !mem_we_in;
    misaligned = 1'b0;
    store_be   = 4'b1111;
    store_data = rs2_data_in;
    load_data  = '0;
    shifted    = dmem_rdata >> {byte_off, 3'b000};

    case (func3[1:0])
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = alu_in[0];
      default: misaligned = |alu_in[1:0];
    endcase
    misaligned = misaligned && (is_load || is_store);
    access     = (is_load || is_store) && !misaligned;

    case (func3[1:0])
      2'b00: begin
        store_be   = 4'b0001 << byte_off;
        store_data = {4{rs2_data_in[7:0]}};
      end
      2'b01: begin
        store_be   = 4'b0011 << byte_off;
        store_data = {2{rs2_data_in[15:0]}};
      end
      default: begin
        store_be   = 4'b1111;
        store_data = rs2_data_in;
      end
    endcase

    case (func3)
      3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_data = {24'd0, shifted[7:0]};
      3'b101:  load_data = {16'd0, shifted[15:0]};
      default: load_data = shifted;
    endcase

    wb_data_sel = (is_load && access) ? load_data : alu_in;
  end

  // FSM next state plus request/stall generation; ack only matters with a request
  always_comb begin
    state_d   = state_q;
    dmem_req  = 1'b0;
    mem_stall = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (access) begin
          dmem_req = 1'b1;
          if (!dmem_ack) begin
            mem_stall = 1'b1;
            state_d   = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (access) begin
          dmem_req = 1'b1;
          if (dmem_ack) begin
            state_d = S_IDLE;
          end else begin
            mem_stall = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (reset) begin
      dmem_req  = 1'b0;
      mem_stall = 1'b0;
    end
  end

  // Memory port and forwarding drive
  always_comb begin
    dmem_addr     = {alu_in[31:2], 2'b00};
    dmem_we       = dmem_req && is_store;
    dmem_be       = is_store ? store_be : 4'b1111;
    dmem_wdata    = store_data;
    df_mem_reg    = wb_reg_in;
    df_mem_enable = wb_enable_in && !mem_stall && !misaligned;
    df_mem_data   = mem_stall ? '0 : wb_data_sel;
  end

  // Next values for the WB register: bubble while stalled
  always_comb begin
    pc_d      = pc_in;
    iw_d      = iw_in;
    wb_data_d = wb_data_sel;
    wb_reg_d  = wb_reg_in;
    wb_en_d   = wb_enable_in && !misaligned;
    mis_d     = misaligned;
    if (mem_stall) begin
      iw_d      = NOP_IW;
      wb_data_d = '0;
      wb_reg_d  = '0;
      wb_en_d   = 1'b0;
      mis_d     = 1'b0;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // WB pipeline register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q      <= '0;
      iw_q      <= '0;
      wb_data_q <= '0;
      wb_reg_q  <= '0;
      wb_en_q   <= 1'b0;
      mis_q     <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      iw_q      <= iw_d;
      wb_data_q <= wb_data_d;
      wb_reg_q  <= wb_reg_d;
      wb_en_q   <= wb_en_d;
      mis_q     <= mis_d;
    end
  end

  assign pc_out        = pc_q;
  assign iw_out        = iw_q;
  assign wb_data_out   = wb_data_q;
  assign wb_reg_out    = wb_reg_q;
  assign wb_enable_out = wb_en_q;
  assign misalign_err  = mis_q;

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: directed vector table, multi-cycle corner sequences
// and a randomized instruction stream against a behavioural model.
module tb_mem_stage;

  logic        clk;
  logic        reset;
  logic [31:0] pc_in, iw_in, alu_in, rs2_data_in;
  logic [4:0]  wb_reg_in;
  logic        wb_enable_in, mem_we_in;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic        mem_stall;
  logic        df_mem_enable;
  logic [4:0]  df_mem_reg;
  logic [31:0] df_mem_data;
  logic [31:0] pc_out, iw_out, wb_data_out;
  logic [4:0]  wb_reg_out;
  logic        wb_enable_out, misalign_err;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [6:0] OP_LD  = 7'h03;
  localparam logic [6:0] OP_ST  = 7'h23;
  localparam logic [6:0] OP_ALU = 7'h33;

  mem_stage dut (
    .clk(clk), .reset(reset),
    .pc_in(pc_in), .iw_in(iw_in), .alu_in(alu_in), .rs2_data_in(rs2_data_in),
    .wb_reg_in(wb_reg_in), .wb_enable_in(wb_enable_in), .mem_we_in(mem_we_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack), .mem_stall(mem_stall),
    .df_mem_enable(df_mem_enable), .df_mem_reg(df_mem_reg), .df_mem_data(df_mem_data),
    .pc_out(pc_out), .iw_out(iw_out), .wb_data_out(wb_data_out),
    .wb_reg_out(wb_reg_out), .wb_enable_out(wb_enable_out), .misalign_err(misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] iw;
    logic [31:0] alu;
    logic [31:0] rs2;
    logic [31:0] rdata;
    logic        mem_we;
    logic        exp_req;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic        chk_data;
    logic [31:0] exp_data;
    logic        exp_mis;
  } vec_t;

  vec_t vt[16];

  function automatic logic [31:0] mk(input logic [6:0] opc, input logic [2:0] f3);
    return {17'd0, f3, 5'd0, opc};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] iw, input logic [31:0] alu,
                       input logic [31:0] rs2, input logic we, input logic [4:0] rd,
                       input logic en, input logic [31:0] rdata, input logic ack);
    pc_in = pc; iw_in = iw; alu_in = alu; rs2_data_in = rs2; mem_we_in = we;
    wb_reg_in = rd; wb_enable_in = en; dmem_rdata = rdata; dmem_ack = ack;
  endtask

  task automatic chk_bubble(input string name, input logic [31:0] pc);
    chk({name, "_bub_iw"}, iw_out, 32'h0000_0013);
    chk({name, "_bub_en"}, 32'(wb_enable_out), 32'd0);
    chk({name, "_bub_data"}, wb_data_out, 32'd0);
    chk({name, "_bub_reg"}, 32'(wb_reg_out), 32'd0);
    chk({name, "_bub_pc"}, pc_out, pc);
  endtask

  // Behavioural model of load extraction: byte/half/word selection by offset
  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] rdata,
                                             input logic [31:0] addr);
    logic [31:0] v;
    int unsigned sz;
    v  = rdata >> (8 * (addr % 4));
    sz = 1 << f3[1:0];
    if (sz == 1) begin
      v = v % 256;
      if (!f3[2] && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (sz == 2) begin
      v = v % 65536;
      if (!f3[2] && v >= 32768) v = v + 32'hFFFF_0000;
    end
    return v;
  endfunction

  initial begin
    vt[0]  = '{mk(OP_ALU,3'd0), 32'h1234, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 1'b1, 32'h1234, 1'b0};
    vt[1]  = '{mk(OP_LD,3'd0), 32'h103, 32'h0, 32'h80FF_FF7F, 1'b0, 1'b1, 4'hF, 32'h0, 1'b1, 32'hFFFF_FF80, 1'b0};
    vt[2]  = '{mk(OP_LD,3'd4), 32'h101, 32'h0, 32'h1234_5678, 1'b0, 1'b1, 4'hF, 32'h0, 1'b1, 32'h56, 1'b0};
    vt[3]  = '{mk(OP_LD,3'd1), 32'h102, 32'h0, 32'h8001_0000, 1'b0, 1'b1, 4'hF, 32'h0, 1'b1, 32'hFFFF_8001, 1'b0};
    vt[4]  = '{mk(OP_LD,3'd5), 32'h102, 32'h0, 32'h8001_0000, 1'b0, 1'b1, 4'hF, 32'h0, 1'b1, 32'h0000_8001, 1'b0};
    vt[5]  = '{mk(OP_LD,3'd2), 32'h200, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1, 4'hF, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0};
    vt[6]  = '{mk(OP_ST,3'd0), 32'h201, 32'hAABB_CC11, 32'h0, 1'b1, 1'b1, 4'b0010, 32'h1111_1111, 1'b1, 32'h201, 1'b0};
    vt[7]  = '{mk(OP_ST,3'd1), 32'h202, 32'hABCD_1234, 32'h0, 1'b1, 1'b1, 4'b1100, 32'h1234_1234, 1'b1, 32'h202, 1'b0};
    vt[8]  = '{mk(OP_ST,3'd2), 32'h300, 32'hCAFE_F00D, 32'h0, 1'b1, 1'b1, 4'b1111, 32'hCAFE_F00D, 1'b1, 32'h300, 1'b0};
    vt[9]  = '{mk(OP_LD,3'd2), 32'h301, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0, 1'b1};
    vt[10] = '{mk(OP_ST,3'd1), 32'h203, 32'h1111, 32'h0, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0, 1'b1};
    vt[11] = '{mk(OP_LD,3'd1), 32'h101, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0, 1'b1};
    vt[12] = '{mk(OP_ST,3'd0), 32'h203, 32'h1234_56EE, 32'h0, 1'b1, 1'b1, 4'b1000, 32'hEEEE_EEEE, 1'b1, 32'h203, 1'b0};
    vt[13] = '{mk(OP_LD,3'd0), 32'h100, 32'h0, 32'h0000_007F, 1'b0, 1'b1, 4'hF, 32'h0, 1'b1, 32'h7F, 1'b0};
    vt[14] = '{mk(OP_ST,3'd2), 32'h302, 32'h5555, 32'h0, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0, 1'b1};
    vt[15] = '{mk(OP_ST,3'd1), 32'h204, 32'h0000_BEEF, 32'h0, 1'b1, 1'b1, 4'b0011, 32'hBEEF_BEEF, 1'b1, 32'h204, 1'b0};

    // Reset: outputs cleared, no request even with a load presented
    reset = 1'b1;
    drive(32'h40, mk(OP_LD,3'd2), 32'h100, 32'h0, 1'b0, 5'd3, 1'b1, 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_stall", 32'(mem_stall), 32'd0);
    chk("rst_iw", iw_out, 32'd0);
    chk("rst_pc", pc_out, 32'd0);
    chk("rst_en", 32'(wb_enable_out), 32'd0);
    chk("rst_mis", 32'(misalign_err), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Directed vector table, ack in the same cycle
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive(32'h1000 + 32'(4 * i), vt[i].iw, vt[i].alu, vt[i].rs2, vt[i].mem_we,
            5'(i + 1), 1'b1, vt[i].rdata, 1'b1);
      #1;
      chk($sformatf("v%0d_req", i), 32'(dmem_req), 32'(vt[i].exp_req));
      chk($sformatf("v%0d_stall", i), 32'(mem_stall), 32'd0);
      chk($sformatf("v%0d_dfen", i), 32'(df_mem_enable), 32'(!vt[i].exp_mis));
      chk($sformatf("v%0d_dfreg", i), 32'(df_mem_reg), 32'(i + 1));
      if (vt[i].exp_req) begin
        chk($sformatf("v%0d_addr", i), dmem_addr, vt[i].alu & 32'hFFFF_FFFC);
        chk($sformatf("v%0d_be", i), 32'(dmem_be), 32'(vt[i].exp_be));
        chk($sformatf("v%0d_we", i), 32'(dmem_we), 32'(vt[i].mem_we));
        if (vt[i].mem_we) chk($sformatf("v%0d_wdata", i), dmem_wdata, vt[i].exp_wdata);
      end
      if (vt[i].chk_data) chk($sformatf("v%0d_dfdata", i), df_mem_data, vt[i].exp_data);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_wben", i), 32'(wb_enable_out), 32'(!vt[i].exp_mis));
      chk($sformatf("v%0d_mis", i), 32'(misalign_err), 32'(vt[i].exp_mis));
      chk($sformatf("v%0d_iw", i), iw_out, vt[i].iw);
      chk($sformatf("v%0d_pc", i), pc_out, 32'h1000 + 32'(4 * i));
      chk($sformatf("v%0d_rd", i), 32'(wb_reg_out), 32'(i + 1));
      if (vt[i].chk_data) chk($sformatf("v%0d_wbdata", i), wb_data_out, vt[i].exp_data);
    end

    // SH acked after two wait cycles: two bubbles then the store
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      drive(32'h2000, mk(OP_ST,3'd1), 32'h202, 32'hABCD_1234, 1'b1, 5'd7, 1'b1, 32'h0, c == 2);
      #1;
      chk($sformatf("sh_req%0d", c), 32'(dmem_req), 32'd1);
      chk($sformatf("sh_stall%0d", c), 32'(mem_stall), 32'(c < 2));
      chk($sformatf("sh_be%0d", c), 32'(dmem_be), 32'(4'b1100));
      chk($sformatf("sh_wdata%0d", c), dmem_wdata, 32'h1234_1234);
      chk($sformatf("sh_addr%0d", c), dmem_addr, 32'h200);
      @(posedge clk);
      #1;
      if (c < 2) chk_bubble($sformatf("sh%0d", c), 32'h2000);
    end
    chk("sh_iw", iw_out, mk(OP_ST,3'd1));
    chk("sh_en", 32'(wb_enable_out), 32'd1);
    chk("sh_rd", 32'(wb_reg_out), 32'd7);

    // LHU acked on the third cycle: forwarding held off until ack
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      drive(32'h2100, mk(OP_LD,3'd5), 32'h402, 32'h0, 1'b0, 5'd9, 1'b1, 32'h8001_0000, c == 2);
      #1;
      chk($sformatf("lhu_dfen%0d", c), 32'(df_mem_enable), 32'(c == 2));
      if (c == 2) chk("lhu_dfdata", df_mem_data, 32'h0000_8001);
      @(posedge clk);
      #1;
    end
    chk("lhu_wbdata", wb_data_out, 32'h0000_8001);
    chk("lhu_wben", 32'(wb_enable_out), 32'd1);

    // Reset during WAIT abandons the access; a later stray ack is ignored
    @(negedge clk);
    drive(32'h2200, mk(OP_LD,3'd2), 32'h500, 32'h0, 1'b0, 5'd4, 1'b1, 32'h0, 1'b0);
    #1;
    chk("rw_stall_pre", 32'(mem_stall), 32'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rw_req", 32'(dmem_req), 32'd0);
    chk("rw_stall", 32'(mem_stall), 32'd0);
    chk("rw_iw", iw_out, 32'd0);
    chk("rw_pc", pc_out, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    drive(32'h2300, mk(OP_ALU,3'd0), 32'h77, 32'h0, 1'b0, 5'd2, 1'b1, 32'hFFFF_FFFF, 1'b1);
    #1;
    chk("rw_stray_req", 32'(dmem_req), 32'd0);
    chk("rw_stray_stall", 32'(mem_stall), 32'd0);
    @(posedge clk);
    #1;
    chk("rw_after_data", wb_data_out, 32'h77);
    chk("rw_after_iw", iw_out, mk(OP_ALU,3'd0));
    @(negedge clk);
    drive(32'h2304, mk(OP_LD,3'd2), 32'h600, 32'h0, 1'b0, 5'd6, 1'b1, 32'h1357_9BDF, 1'b0);
    #1;
    chk("rw_new_stall", 32'(mem_stall), 32'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    dmem_ack = 1'b1;
    #1;
    chk("rw_new_ack_stall", 32'(mem_stall), 32'd0);
    @(posedge clk);
    #1;
    chk("rw_new_data", wb_data_out, 32'h1357_9BDF);

    // Randomized instruction stream against the behavioural model
    for (int n = 0; n < 300; n++) begin
      int unsigned kind, lat, sz;
      logic [2:0]  f3;
      logic [31:0] alu, rs2, rdata, pc, iw, exp_data, exp_wd;
      logic [3:0]  exp_be;
      logic [4:0]  rd;
      logic        en, is_mem, is_st, mis, acc;
      kind = $urandom_range(0, 2);
      case ($urandom_range(0, 4))
        0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd2; 3: f3 = 3'd4; default: f3 = 3'd5;
      endcase
      if (kind == 2 && f3[2]) f3[2] = 1'b0;
      alu   = $urandom;
      if ($urandom_range(0, 1) == 1) alu = alu & 32'hFFFF_FFFC;
      rs2   = $urandom;
      rdata = $urandom;
      pc    = 32'h8000 + 32'(4 * n);
      rd    = 5'($urandom);
      en    = 1'($urandom);
      is_mem = (kind != 0);
      is_st  = (kind == 2);
      iw     = kind == 1 ? mk(OP_LD, f3) : (kind == 2 ? mk(OP_ST, f3) : mk(OP_ALU, f3));
      sz     = 1 << f3[1:0];
      mis    = is_mem && ((alu % sz) != 0);
      acc    = is_mem && !mis;
      lat    = acc ? $urandom_range(0, 3) : 0;
      exp_be = 4'hF;
      exp_wd = rs2;
      if (is_st && sz == 1) begin exp_be = 4'(1 << (alu % 4)); exp_wd = (rs2 % 256) * 32'h0101_0101; end
      if (is_st && sz == 2) begin exp_be = 4'(3 << (alu % 4)); exp_wd = (rs2 % 65536) * 32'h0001_0001; end
      exp_data = (kind == 1 && acc) ? model_load(f3, rdata, alu) : alu;
      for (int c = 0; c <= int'(lat); c++) begin
        logic ack;
        ack = acc ? (c == int'(lat)) : 1'($urandom);
        @(negedge clk);
        drive(pc, iw, alu, rs2, is_st, rd, en, rdata, ack);
        #1;
        chk("r_req", 32'(dmem_req), 32'(acc));
        chk("r_stall", 32'(mem_stall), 32'(acc && c < int'(lat)));
        if (acc) begin
          chk("r_addr", dmem_addr, alu - (alu % 4));
          chk("r_we", 32'(dmem_we), 32'(is_st));
          chk("r_be", 32'(dmem_be), 32'(exp_be));
          if (is_st) chk("r_wdata", dmem_wdata, exp_wd);
        end
        if (c == int'(lat)) begin
          chk("r_dfen", 32'(df_mem_enable), 32'(en && !mis));
          if (!mis) chk("r_dfdata", df_mem_data, exp_data);
        end else begin
          chk("r_dfen_stall", 32'(df_mem_enable), 32'd0);
        end
        @(posedge clk);
        #1;
        if (c < int'(lat)) begin
          chk_bubble("r", pc);
        end else begin
          chk("r_iw", iw_out, iw);
          chk("r_pc", pc_out, pc);
          chk("r_rd", 32'(wb_reg_out), 32'(rd));
          chk("r_wben", 32'(wb_enable_out), 32'(en && !mis));
          chk("r_mis", 32'(misalign_err), 32'(mis));
          if (!mis) chk("r_wbdata", wb_data_out, exp_data);
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have port: clk  in  1  single system clock; all state changes on its rising edge.
REQ-002 SHALL have port: reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL have ports from EX: pc_in 32, iw_in 32, alu_in 32 (ALU result / effective address), rs2_data_in 32, wb_reg_in 5, wb_enable_in 1, mem_we_in 1; all inputs.
REQ-004 SHALL have data-memory ports: dmem_req out 1, dmem_we out 1, dmem_addr out 32 (word-aligned, addr[1:0]=0), dmem_wdata out 32, dmem_be out 4, dmem_rdata in 32, dmem_ack in 1.
REQ-005 SHALL have port: mem_stall  out  1  upstream stages hold every *_in value while this is 1.
REQ-006 SHALL have forwarding outputs to ID: df_mem_enable 1, df_mem_reg 5, df_mem_data 32.
REQ-007 SHALL have registered outputs to WB: pc_out 32, iw_out 32, wb_data_out 32, wb_reg_out 5, wb_enable_out 1, misalign_err 1.

Function
REQ-008 SHALL classify the input as a load when iw_in[6:0]=0000011, a store when mem_we_in=1, otherwise a non-memory op; func3=iw_in[14:12].
REQ-009 SHALL implement a 2-state FSM: IDLE and WAIT; reset state IDLE.
REQ-010 IDLE: an aligned load/store SHALL assert dmem_req combinationally; dmem_ack=1 in the same cycle completes it and the state stays IDLE; dmem_ack=0 moves to WAIT.
REQ-011 WAIT: dmem_req SHALL stay asserted with unchanged addr/we/wdata/be; dmem_ack=1 completes and returns to IDLE.
REQ-012 mem_stall SHALL equal (aligned load or store) AND NOT dmem_ack, in both states.
REQ-013 Alignment: LH/LHU/SH SHALL require alu_in[0]=0; LW/SW SHALL require alu_in[1:0]=00; byte accesses are always aligned.
REQ-014 A misaligned access SHALL issue no request and no stall, and SHALL register misalign_err=1, wb_enable_out=0 for that one instruction.
REQ-015 Stores: SB SHALL set dmem_be=0001<<addr[1:0] and wdata={4{rs2[7:0]}}; SH SHALL set be=0011<<addr[1:0] and wdata={2{rs2[15:0]}}; SW SHALL set be=1111 and wdata=rs2.
REQ-016 Loads SHALL set dmem_we=0, be=1111; dmem_we=1 only for stores.
REQ-017 Load data SHALL come from dmem_rdata shifted right by 8*addr[1:0]: LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
REQ-018 wb_data_out SHALL register the extracted load data for loads, alu_in for every other op.
REQ-019 On any edge where mem_stall=1, WB outputs SHALL register a bubble: iw_out=32'h00000013, wb_enable_out=0, wb_reg_out=0, wb_data_out=0, misalign_err=0; pc_out=pc_in.
REQ-020 On a non-stalled edge, pc_out, iw_out, wb_reg_out SHALL register their inputs and wb_enable_out SHALL register wb_enable_in (forced 0 on misalign).
REQ-021 Non-memory ops and completed accesses SHALL have 1-cycle latency to WB outputs; an access acked after N WAIT cycles adds N bubbles.
REQ-022 df_mem_reg SHALL equal wb_reg_in; df_mem_enable SHALL equal wb_enable_in AND NOT mem_stall AND NOT misaligned; df_mem_data SHALL equal the value that will be registered into wb_data_out.
REQ-023 dmem_ack SHALL be ignored when no request is asserted.

Reset
REQ-024 While reset=1 all registered outputs SHALL be 0 (iw_out=0, misalign_err=0), the FSM SHALL be IDLE, dmem_req and mem_stall SHALL be 0.
REQ-025 Reset asserted in WAIT SHALL abandon the outstanding access immediately; an ack arriving after reset deassertion and before a new request is ignored.

Verification
REQ-026 ADD, alu_in=0x1234, wb_reg_in=5, wb_enable_in=1 -> next edge wb_data_out=0x1234, wb_reg_out=5, no dmem_req, mem_stall=0.
REQ-027 LB, alu_in=0x103, dmem_rdata=0x80FF_FF7F, ack same cycle -> wb_data_out=0xFFFF_FF80, dmem_addr=0x100, no stall.
REQ-028 SH, alu_in=0x202, rs2=0xABCD_1234, ack after 2 cycles -> dmem_be=1100, wdata=0x1234_1234, mem_stall=1 for 2 cycles, 2 bubbles with iw_out=0x00000013, then WB gets the store.
REQ-029 LW, alu_in=0x301 -> no dmem_req, misalign_err=1, wb_enable_out=0 for one cycle.
REQ-030 LHU, alu_in=0x402, dmem_rdata=0x8001_0000, ack at cycle 3 -> df_mem_enable=0 until ack, then df_mem_data=0x0000_8001.
REQ-031 Reset pulse while in WAIT -> dmem_req=0, mem_stall=0, all outputs 0; a later stray dmem_ack has no effect.
